// File: rtl/moesif_snoop_arbiter.sv
// Round-robin snoop-bus arbiter that owns the MOESIF state of one shared line.
// Optional 16-bit saturating statistics counters: define MOESIF_ARB_STATS_EN.
module moesif_snoop_arbiter #(
  parameter int N_CORES      = 4,
  parameter int SNOOP_CYCLES = 2,
  parameter int CW           = $clog2(N_CORES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CORES-1:0]     req,
  input  logic [N_CORES-1:0]     req_write,
  input  logic [N_CORES-1:0]     req_evict,
  output logic [N_CORES-1:0]     gnt,
  output logic [N_CORES-1:0]     ack,
  output logic [2:0]             ack_state,
  output logic                   snoop_valid,
  output logic                   snoop_inv,
  output logic [CW-1:0]          snoop_src,
  output logic                   wb_valid,
  output logic [CW-1:0]          wb_core,
  output logic                   busy,
  output logic [3*N_CORES-1:0]   line_state
`ifdef MOESIF_ARB_STATS_EN
  ,
  output logic [15:0]            stat_txn,
  output logic [15:0]            stat_snoop,
  output logic [15:0]            stat_wb
`endif
);

  localparam logic [2:0] S_I = 3'b000;
  localparam logic [2:0] S_S = 3'b001;
  localparam logic [2:0] S_E = 3'b010;
  localparam logic [2:0] S_M = 3'b011;
  localparam logic [2:0] S_O = 3'b100;
  localparam logic [2:0] S_F = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SNOOP  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_EVICT = 2'd2;

  localparam int SCW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;
  localparam logic [SCW-1:0] SNP_LAST  = SCW'(SNOOP_CYCLES - 1);
  localparam logic [CW-1:0]  LAST_CORE = CW'(N_CORES - 1);

  // Unused encodings 110/111 read back as INVALID.
  function automatic logic [2:0] sanitize(input logic [2:0] s);
    return ((s == 3'b110) || (s == 3'b111)) ? S_I : s;
  endfunction

  // Downgrade applied to other sharers when a reader takes the line.
  function automatic logic [2:0] demote(input logic [2:0] s);
    logic [2:0] r;
    r = s;
    if (s == S_M) r = S_O;
    else if ((s == S_E) || (s == S_F)) r = S_S;
    return r;
  endfunction

  function automatic logic is_dirty(input logic [2:0] s);
    return (s == S_M) || (s == S_O);
  endfunction

  logic [1:0]           fsm_q, fsm_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        win_q, win_d;
  logic [1:0]           typ_q, typ_d;
  logic [SCW-1:0]       cnt_q, cnt_d;
  logic [3*N_CORES-1:0] line_q, line_d;

  logic [2:0]           cur [N_CORES];
  logic                 pick_vld;
  logic [CW-1:0]        pick_idx;
  logic [1:0]           pick_typ;
  logic                 pick_snoop;
  int                   idx;
  logic                 others_valid;
  logic                 wb_v;
  logic [CW-1:0]        wb_c;
  logic [N_CORES-1:0]   win_oh;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      cur[i] = sanitize(line_q[3*i +: 3]);
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = CW'(idx);
      end
    end
  end

  always_comb begin
    if (req_write[pick_idx])      pick_typ = T_WRITE;
    else if (req_evict[pick_idx]) pick_typ = T_EVICT;
    else                          pick_typ = T_READ;
    pick_snoop = ((pick_typ == T_READ) && (cur[pick_idx] == S_I)) ||
                 ((pick_typ == T_WRITE) && (cur[pick_idx] != S_M) && (cur[pick_idx] != S_E));
  end

  // Coherence transition for the latched transaction, committed in UPDATE.
  always_comb begin
    line_d       = line_q;
    wb_v         = 1'b0;
    wb_c         = '0;
    others_valid = 1'b0;
    for (int j = 0; j < N_CORES; j++) begin
      if ((j != int'(win_q)) && (cur[j] != S_I)) others_valid = 1'b1;
    end
    case (typ_q)
      T_READ: begin
        if (cur[win_q] == S_I) begin
          for (int j = 0; j < N_CORES; j++) begin
            if (j == int'(win_q)) line_d[3*j +: 3] = others_valid ? S_F : S_E;
            else if (others_valid) line_d[3*j +: 3] = demote(cur[j]);
          end
        end
      end
      T_WRITE: begin
        for (int j = 0; j < N_CORES; j++) begin
          if (j == int'(win_q)) begin
            line_d[3*j +: 3] = S_M;
          end else begin
            if (is_dirty(cur[j]) && !wb_v) begin
              wb_v = 1'b1;
              wb_c = CW'(j);
            end
            line_d[3*j +: 3] = S_I;
          end
        end
      end
      default: begin
        if (is_dirty(cur[win_q])) begin
          wb_v = 1'b1;
          wb_c = win_q;
        end
        for (int j = 0; j < N_CORES; j++) begin
          if (j == int'(win_q)) line_d[3*j +: 3] = S_I;
        end
      end
    endcase
  end

  always_comb begin
    fsm_d = fsm_q;
    ptr_d = ptr_q;
    win_d = win_q;
    typ_d = typ_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d = pick_idx;
          typ_d = pick_typ;
          cnt_d = '0;
          fsm_d = pick_snoop ? ST_SNOOP : ST_UPDATE;
        end
      end
      ST_SNOOP: begin
        if (cnt_q == SNP_LAST) fsm_d = ST_UPDATE;
        else                   cnt_d = cnt_q + 1'b1;
      end
      ST_UPDATE: fsm_d = ST_RESP;
      ST_RESP: begin
        fsm_d = ST_IDLE;
        ptr_d = (win_q == LAST_CORE) ? '0 : win_q + 1'b1;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= ST_IDLE;
      ptr_q  <= '0;
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (fsm_q == ST_UPDATE) line_q <= line_d;
    end
  end

  // Transaction identity is only observed while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    typ_q <= typ_d;
  end

  assign win_oh      = N_CORES'(1) << win_q;
  assign busy        = (fsm_q != ST_IDLE);
  assign gnt         = busy ? win_oh : '0;
  assign ack         = (fsm_q == ST_RESP) ? win_oh : '0;
  assign ack_state   = (fsm_q == ST_RESP) ? cur[win_q] : S_I;
  assign snoop_valid = (fsm_q == ST_SNOOP);
  assign snoop_inv   = (fsm_q == ST_SNOOP) && (typ_q == T_WRITE);
  assign snoop_src   = busy ? win_q : '0;
  assign wb_valid    = (fsm_q == ST_UPDATE) && wb_v;
  assign wb_core     = wb_valid ? wb_c : '0;
  assign line_state  = line_q;

`ifdef MOESIF_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_txn_q, stat_snoop_q, stat_wb_q;
  logic        snoop_entry;

  assign snoop_entry = (fsm_q == ST_IDLE) && pick_vld && pick_snoop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_txn_q   <= '0;
      stat_snoop_q <= '0;
      stat_wb_q    <= '0;
    end else begin
      if (fsm_q == ST_RESP) stat_txn_q   <= sat_inc(stat_txn_q);
      if (snoop_entry)      stat_snoop_q <= sat_inc(stat_snoop_q);
      if (wb_valid)         stat_wb_q    <= sat_inc(stat_wb_q);
    end
  end

  assign stat_txn   = stat_txn_q;
  assign stat_snoop = stat_snoop_q;
  assign stat_wb    = stat_wb_q;
`endif

endmodule
